// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front-end: control encodings, frame
// nibble indices, flag bit positions and the sequencer state enum.
package alu_pkg;

  localparam int unsigned ALU_W  = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned CTRL_W = 3;
  localparam int unsigned SAMT_W = 4;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic [CTRL_W-1:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_SHL  = 3'b100,
    ALU_SHLS = 3'b101,
    ALU_SHR  = 3'b110,
    ALU_SHRS = 3'b111
  } alu_ctrl_e;

  // Position within the full six-nibble frame; chained frames skip A_LO/A_HI.
  localparam logic [IDX_W-1:0] IDX_OP   = 3'd0;
  localparam logic [IDX_W-1:0] IDX_SAMT = 3'd1;
  localparam logic [IDX_W-1:0] IDX_A_LO = 3'd2;
  localparam logic [IDX_W-1:0] IDX_A_HI = 3'd3;
  localparam logic [IDX_W-1:0] IDX_B_LO = 3'd4;
  localparam logic [IDX_W-1:0] IDX_B_HI = 3'd5;

  localparam int unsigned OP_CHAIN_BIT = 3;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EXEC    = 2'd1,
    ST_RESP    = 2'd2
  } seq_state_e;

  function automatic logic [FLAG_W-1:0] pack_flags(
    input logic v, input logic n, input logic z, input logic c);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_V] = v;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/alu_frame_timeout.sv
// Idle-cycle watchdog for a partially received frame; raises a one-cycle abort
// pulse once TIMEOUT consecutive idle cycles have elapsed mid-frame.
module alu_frame_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic in_valid,
  input  logic accept,
  output logic frame_err,
  output logic abort_next_c
);

  localparam bit          ENABLE = (TIMEOUT != 0);
  localparam int unsigned CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = ENABLE ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] count;

  // The cycle that would make the idle count reach TIMEOUT becomes the abort.
  assign abort_next_c = ENABLE && active && !in_valid && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      frame_err <= 1'b0;
    end else if (frame_err || !active || accept) begin
      count     <= '0;
      frame_err <= 1'b0;
    end else if (abort_next_c) begin
      count     <= '0;
      frame_err <= 1'b1;
    end else if (ENABLE && !in_valid) begin
      count     <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Nibble-stream command front-end for the 8-bit ALU: assembles a frame, drives
// registered operands, captures the result one cycle later and returns it.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NIB_W-1:0]  in_nibble,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SAMT_W-1:0] alu_s_amt,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_negative,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [FLAG_W-1:0] out_flags,
  output logic              frame_err,
  output logic              busy
);

  seq_state_e        state;
  logic [IDX_W-1:0]  idx;
  logic [NIB_W-1:0]  op_reg;
  logic [SAMT_W-1:0] samt_reg;
  logic [DATA_W-1:0] a_reg;
  logic [NIB_W-1:0]  b_lo_reg;
  logic [DATA_W-1:0] chain_reg;
  logic              accept;
  logic              wd_active;
  logic              abort_next_c;

  assign accept    = in_valid && in_ready;
  assign wd_active = (state == ST_COLLECT) && (idx != IDX_OP) && !frame_err;

  alu_frame_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk          (clk),
    .rst          (rst),
    .active       (wd_active),
    .in_valid     (in_valid),
    .accept       (accept),
    .frame_err    (frame_err),
    .abort_next_c (abort_next_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_COLLECT;
      idx        <= IDX_OP;
      in_ready   <= 1'b1;
      op_reg     <= '0;
      samt_reg   <= '0;
      a_reg      <= '0;
      b_lo_reg   <= '0;
      chain_reg  <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s_amt  <= '0;
      alu_ctrl   <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (frame_err) begin
            // Abort cycle: drop the partial frame, keep the chain register.
            idx      <= IDX_OP;
            in_ready <= 1'b1;
          end else begin
            in_ready <= !abort_next_c;
            if (accept) begin
              case (idx)
                IDX_OP: begin
                  op_reg <= in_nibble;
                  idx    <= IDX_SAMT;
                end
                IDX_SAMT: begin
                  samt_reg <= in_nibble;
                  idx      <= op_reg[OP_CHAIN_BIT] ? IDX_B_LO : IDX_A_LO;
                end
                IDX_A_LO: begin
                  a_reg[NIB_W-1:0] <= in_nibble;
                  idx              <= IDX_A_HI;
                end
                IDX_A_HI: begin
                  a_reg[NIB_W +: NIB_W] <= in_nibble;
                  idx                   <= IDX_B_LO;
                end
                IDX_B_LO: begin
                  b_lo_reg <= in_nibble;
                  idx      <= IDX_B_HI;
                end
                default: begin
                  alu_a     <= op_reg[OP_CHAIN_BIT] ? chain_reg : a_reg;
                  alu_b     <= {in_nibble, b_lo_reg};
                  alu_s_amt <= samt_reg;
                  alu_ctrl  <= op_reg[CTRL_W-1:0];
                  idx       <= IDX_OP;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ST_EXEC;
                end
              endcase
            end
          end
        end
        ST_EXEC: begin
          out_result <= alu_result;
          out_flags  <= pack_flags(alu_overflow, alu_negative, alu_zero, alu_carry);
          chain_reg  <= alu_result;
          out_valid  <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            idx       <= IDX_OP;
            state     <= ST_COLLECT;
          end
        end
        default: begin
          state <= ST_COLLECT;
        end
      endcase
    end
  end

endmodule
